// File: rtl/ft_pkg.sv
// Shared state encoding, defaults and helpers for the compressed-decoder fault-tolerance controller.
package ft_pkg;

   localparam int CDEC_MAX_RETRY  = 2;
   localparam int CDEC_STAT_CNT_W = 16;

   typedef enum logic [1:0] {
      CDEC_RUN    = 2'd0,
      CDEC_STALL  = 2'd1,
      CDEC_REPLAY = 2'd2,
      CDEC_FATAL  = 2'd3
   } cdec_state_e;

   // True when at least two of the three replicas are flagged, so no majority vote can be formed.
   function automatic logic two_or_more(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_cnt.sv
// Saturating event counter with synchronous clear; counts on the clock after inc_i, no backpressure.
module cv32e40p_ft_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_cdec_ctrl.sv
// Replay/fatal controller for the TMR compressed decoder; all outputs registered, one-cycle state latency.
// Statistics counters are built only when CDEC_FT_STATS_EN is defined; otherwise they read 0.
module cv32e40p_ft_cdec_ctrl
   import ft_pkg::*;
#(
   parameter int MAX_RETRY = CDEC_MAX_RETRY,
   parameter int CNT_W     = CDEC_STAT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid_i,
   input  logic             err_detected_i,
   input  logic             err_corrected_i,
   input  logic [2:0]       is_broken_i,
   input  logic             force_we_i,
   input  logic [2:0]       force_mask_i,
   input  logic             clear_i,
   output logic [2:0]       set_broken_o,
   output logic             stall_o,
   output logic             replay_o,
   output logic             fatal_o,
   output logic             reject_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] corr_cnt_o
);

   localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

   cdec_state_e state_q, state_d;
   logic [2:0]  retry_q, retry_d;
   logic [2:0]  force_q, force_d;
   logic        reject_q, reject_d;
   logic        ue;
   logic        no_majority;
   logic        force_bad;

   assign ue          = instr_valid_i & err_detected_i & ~err_corrected_i;
   assign no_majority = two_or_more(is_broken_i | force_q);
   assign force_bad   = two_or_more(force_mask_i | is_broken_i);

   // clear_i outranks the loss-of-majority escape, which outranks a normal UE.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if (clear_i) begin
         state_d = CDEC_RUN;
         retry_d = '0;
      end else begin
         if (no_majority && (state_q != CDEC_FATAL)) begin
            state_d = CDEC_FATAL;
         end else begin
            case (state_q)
               CDEC_RUN: begin
                  if (ue) begin
                     state_d = (retry_q < RETRY_LIM) ? CDEC_STALL : CDEC_FATAL;
                  end
               end
               CDEC_STALL:  state_d = CDEC_REPLAY;
               CDEC_REPLAY: state_d = CDEC_RUN;
               default:     state_d = CDEC_FATAL;
            endcase
         end
         if (state_q == CDEC_REPLAY) begin
            retry_d = retry_q + 3'd1;
         end else if ((state_q == CDEC_RUN) && instr_valid_i && !ue) begin
            retry_d = '0;
         end
      end
   end

   // A forced mask that would itself leave no majority is refused rather than applied.
   always_comb begin
      force_d  = force_q;
      reject_d = 1'b0;
      if (force_we_i) begin
         if (force_bad) begin
            reject_d = 1'b1;
         end else begin
            force_d = force_mask_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CDEC_RUN;
         retry_q  <= '0;
         force_q  <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         retry_q  <= retry_d;
         force_q  <= force_d;
         reject_q <= reject_d;
      end
   end

   assign set_broken_o = force_q;
   assign stall_o      = (state_q != CDEC_RUN);
   assign replay_o     = (state_q == CDEC_REPLAY);
   assign fatal_o      = (state_q == CDEC_FATAL);
   assign reject_o     = reject_q;
   assign state_o      = state_q;

`ifdef CDEC_FT_STATS_EN
   cv32e40p_ft_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clear_i),
      .inc_i (instr_valid_i & err_detected_i),
      .cnt_o (err_cnt_o)
   );

   cv32e40p_ft_sat_cnt #(.W(CNT_W)) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clear_i),
      .inc_i (instr_valid_i & err_corrected_i),
      .cnt_o (corr_cnt_o)
   );
`else
   assign err_cnt_o  = '0;
   assign corr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_ft_cdec_ctrl.sv
// Directed bench for cv32e40p_ft_cdec_ctrl with a cycle-level reference model checked every cycle.
module tb_cv32e40p_ft_cdec_ctrl;

   localparam int MAXR = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int RUN = 0, STALL = 1, REPLAY = 2, FATAL = 3;
`ifdef CDEC_FT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_valid = 1'b0;
   logic          det = 1'b0;
   logic          corr = 1'b0;
   logic          force_we = 1'b0;
   logic          clear = 1'b0;
   logic [2:0]    broken = 3'b000;
   logic [2:0]    mask = 3'b000;
   logic [2:0]    set_broken_o;
   logic          stall_o, replay_o, fatal_o, reject_o;
   logic [1:0]    state_o;
   logic [CW-1:0] err_cnt_o, corr_cnt_o;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int       m_state = RUN;
   int       m_retry = 0;
   int       m_err   = 0;
   int       m_corr  = 0;
   bit [2:0] m_force = 3'b000;
   bit       m_reject = 1'b0;

   cv32e40p_ft_cdec_ctrl #(.MAX_RETRY(MAXR), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .instr_valid_i   (instr_valid),
      .err_detected_i  (det),
      .err_corrected_i (corr),
      .is_broken_i     (broken),
      .force_we_i      (force_we),
      .force_mask_i    (mask),
      .clear_i         (clear),
      .set_broken_o    (set_broken_o),
      .stall_o         (stall_o),
      .replay_o        (replay_o),
      .fatal_o         (fatal_o),
      .reject_o        (reject_o),
      .state_o         (state_o),
      .err_cnt_o       (err_cnt_o),
      .corr_cnt_o      (corr_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model advances on each rising edge from the inputs held since the previous falling edge.
   always @(posedge clk) begin : mdl
      int ns, nr;
      bit ue, dead;
      if (rst) begin
         m_state = RUN; m_retry = 0; m_err = 0; m_corr = 0;
         m_force = 3'b000; m_reject = 1'b0;
      end else begin
         ue   = instr_valid && det && !corr;
         dead = $countones(broken | m_force) >= 2;
         ns = m_state;
         nr = m_retry;
         if (clear) begin
            ns = RUN;
            nr = 0;
         end else begin
            if (dead && m_state != FATAL)           ns = FATAL;
            else if (m_state == RUN && ue)          ns = (m_retry == MAXR) ? FATAL : STALL;
            else if (m_state == STALL)              ns = REPLAY;
            else if (m_state == REPLAY)             ns = RUN;
            if (m_state == REPLAY)                  nr = m_retry + 1;
            else if (m_state == RUN && instr_valid && !ue) nr = 0;
         end
         if (clear) begin
            m_err = 0;
            m_corr = 0;
         end else begin
            if (STATS && instr_valid && det && m_err < CMAX)   m_err++;
            if (STATS && instr_valid && corr && m_corr < CMAX) m_corr++;
         end
         m_reject = 1'b0;
         if (force_we) begin
            if ($countones(mask | broken) >= 2) m_reject = 1'b1;
            else                                 m_force = mask;
         end
         m_state = ns;
         m_retry = nr;
      end
      #1;
      chk("state_o",      int'(state_o),      m_state);
      chk("stall_o",      int'(stall_o),      int'(m_state != RUN));
      chk("replay_o",     int'(replay_o),     int'(m_state == REPLAY));
      chk("fatal_o",      int'(fatal_o),      int'(m_state == FATAL));
      chk("reject_o",     int'(reject_o),     int'(m_reject));
      chk("set_broken_o", int'(set_broken_o), int'(m_force));
      chk("retry_q",      int'(dut.retry_q),  m_retry);
      chk("err_cnt_o",    int'(err_cnt_o),    m_err);
      chk("corr_cnt_o",   int'(corr_cnt_o),   m_corr);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle();
      instr_valid = 1'b0; det = 1'b0; corr = 1'b0;
      force_we = 1'b0; clear = 1'b0;
   endtask

   task automatic ue_once();
      instr_valid = 1'b1; det = 1'b1; corr = 1'b0;
      cyc(1);
      idle();
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst state", int'(state_o), 0);
      chk("rst stall", int'(stall_o), 0);
      chk("rst set_broken", int'(set_broken_o), 0);
      rst = 1'b0;
      cyc(2);

      // Single UE with retry 0: STALL, REPLAY, RUN with retry 1
      instr_valid = 1'b1; cyc(1); idle();
      ue_once();
      chk("ue stall state", int'(state_o), 1);
      chk("ue stall_o", int'(stall_o), 1);
      cyc(1);
      chk("ue replay state", int'(state_o), 2);
      chk("ue replay_o", int'(replay_o), 1);
      cyc(1);
      chk("ue back run", int'(state_o), 0);
      chk("ue retry 1", int'(dut.retry_q), 1);
      chk("ue replay done", int'(replay_o), 0);

      // Three consecutive UEs exhaust MAX_RETRY=2 and go FATAL
      instr_valid = 1'b1; cyc(1); idle();
      chk("retry cleared", int'(dut.retry_q), 0);
      ue_once(); cyc(2);
      ue_once(); cyc(2);
      chk("retry at limit", int'(dut.retry_q), 2);
      ue_once();
      chk("third ue fatal", int'(state_o), 3);
      chk("fatal_o set", int'(fatal_o), 1);
      ue_once();
      chk("fatal sticky", int'(state_o), 3);
      chk("fatal retry held", int'(dut.retry_q), 2);
      clear = 1'b1; cyc(1); idle();
      chk("clear to run", int'(state_o), 0);
      chk("clear retry", int'(dut.retry_q), 0);
      chk("clear fatal_o", int'(fatal_o), 0);

      // UE and clear together: UE ignored, retry zeroed
      ue_once(); cyc(2);
      chk("retry before clr", int'(dut.retry_q), 1);
      instr_valid = 1'b1; det = 1'b1; clear = 1'b1; cyc(1); idle();
      chk("ue+clear run", int'(state_o), 0);
      chk("ue+clear retry", int'(dut.retry_q), 0);

      // Corrected error is not a UE and clears retry
      ue_once(); cyc(2);
      instr_valid = 1'b1; det = 1'b1; corr = 1'b1; cyc(1); idle();
      chk("corrected no stall", int'(state_o), 0);
      chk("corrected clears retry", int'(dut.retry_q), 0);

      // Force mask rejected when it would break majority
      broken = 3'b001; cyc(1);
      force_we = 1'b1; mask = 3'b010; cyc(1); idle();
      chk("reject pulse", int'(reject_o), 1);
      chk("reject keeps mask", int'(set_broken_o), 0);
      cyc(1);
      chk("reject one cycle", int'(reject_o), 0);
      force_we = 1'b1; mask = 3'b001; cyc(1); idle();
      chk("force accepted", int'(set_broken_o), 1);
      chk("force no reject", int'(reject_o), 0);
      broken = 3'b000;
      force_we = 1'b1; mask = 3'b100; cyc(1); idle();
      chk("force 100", int'(set_broken_o), 4);
      broken = 3'b001; cyc(1);
      chk("no majority fatal", int'(state_o), 3);
      broken = 3'b000; clear = 1'b1; cyc(1); idle();
      chk("clear after break", int'(state_o), 0);
      chk("clear keeps force", int'(set_broken_o), 4);
      force_we = 1'b1; mask = 3'b000; cyc(1); idle();

      // Counter saturation and clear
      det = 1'b1; cyc(3); det = 1'b0;
      instr_valid = 1'b1; det = 1'b1; corr = 1'b1; cyc(20); idle();
      chk("err_cnt sat", int'(err_cnt_o), STATS ? 15 : 0);
      chk("corr_cnt sat", int'(corr_cnt_o), STATS ? 15 : 0);
      force_we = 1'b1; mask = 3'b010; cyc(1); idle();
      clear = 1'b1; cyc(1); idle();
      chk("clear err_cnt", int'(err_cnt_o), 0);
      chk("clear corr_cnt", int'(corr_cnt_o), 0);
      chk("clear force kept", int'(set_broken_o), 2);

      // Reset while in REPLAY
      ue_once(); cyc(1);
      chk("pre-rst replay", int'(state_o), 2);
      rst = 1'b1; cyc(1);
      chk("rst replay state", int'(state_o), 0);
      chk("rst replay_o", int'(replay_o), 0);
      chk("rst stall_o", int'(stall_o), 0);
      chk("rst fatal_o", int'(fatal_o), 0);
      chk("rst reject_o", int'(reject_o), 0);
      chk("rst force", int'(set_broken_o), 0);
      chk("rst retry", int'(dut.retry_q), 0);
      rst = 1'b0; cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cv32e40p_ft_cdec_ctrl.md
CV32E40P_FT_CDEC_CTRL -- requirements
Module: cv32e40p_ft_cdec_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 2, SHALL set the number of replays allowed per instruction before the block declares a fatal error; its legal range is 1..7.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the statistics counters.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port instr_valid_i, input, 1 bit: the decoder output is consumed this cycle.
REQ-006 Port err_detected_i, input, 1 bit: OR of the decoder voters' error-detected flags.
REQ-007 Port err_corrected_i, input, 1 bit: OR of the decoder voters' error-corrected flags.
REQ-008 Port is_broken_i, input, 3 bits: per-replica broken flags from the breakage monitors.
REQ-009 Port force_we_i, input, 1 bit: CSR write strobe for the force mask.
REQ-010 Port force_mask_i, input, 3 bits: CSR write data for the force mask.
REQ-011 Port clear_i, input, 1 bit: CSR clear of the fatal state, the retry count and the counters.
REQ-012 Port set_broken_o, output, 3 bits: drives the decoder's set_broken_i.
REQ-013 Port stall_o, output, 1 bit: holds fetch/decode.
REQ-014 Port replay_o, output, 1 bit: one-cycle pulse that requests a refetch of the current instruction.
REQ-015 Port fatal_o, output, 1 bit: sticky unrecoverable-error flag.
REQ-016 Port reject_o, output, 1 bit: one-cycle pulse signalling that a force-mask write was refused.
REQ-017 Port state_o, output, 2 bits: current FSM state.
REQ-018 Ports err_cnt_o and corr_cnt_o, outputs, CNT_W bits each: statistics counters, present only under REQ-033.

Function
REQ-019 An uncorrected error (UE) SHALL be defined as instr_valid_i & err_detected_i & ~err_corrected_i.
REQ-020 The FSM SHALL have four states, encoded RUN=0, STALL=1, REPLAY=2, FATAL=3; stall_o SHALL be 1 whenever state != RUN.
REQ-021 The block SHALL go from RUN to STALL in the cycle after a UE when retry_q < MAX_RETRY, and from RUN to FATAL in the cycle after a UE when retry_q == MAX_RETRY.
REQ-022 STALL SHALL last exactly one cycle and then go to REPLAY; REPLAY SHALL assert replay_o for its single cycle, increment retry_q, and return to RUN.
REQ-023 retry_q (3 bits) SHALL clear to 0 on any cycle in RUN with instr_valid_i=1 and no UE.
REQ-024 A cycle with popcount(is_broken_i | set_broken_o) >= 2 SHALL move any non-FATAL state to FATAL on the next cycle, because no majority is possible.
REQ-025 FATAL SHALL be exited only by clear_i, which moves the FSM to RUN.
REQ-026 fatal_o SHALL equal (state == FATAL).
REQ-027 On force_we_i, force_q SHALL load force_mask_i unless popcount(force_mask_i | is_broken_i) >= 2; in that case force_q is held and reject_o pulses 1 on the next cycle.
REQ-028 set_broken_o SHALL equal force_q, which is registered.
REQ-029 Priority SHALL be rst > clear_i > the FATAL entry of REQ-024 > a UE; a UE in the same cycle as clear_i SHALL be ignored.
REQ-030 clear_i SHALL zero retry_q and the counters but SHALL NOT alter force_q.
REQ-031 err_detected_i and err_corrected_i arriving while state != RUN SHALL NOT change retry_q, but SHALL still count under REQ-033.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL reset to: state RUN, retry_q 0, force_q 0, all counters 0, and stall_o, replay_o, reject_o and fatal_o all 0.

Configuration
REQ-033 Macro CDEC_FT_STATS_EN:
- Defined: err_cnt_o increments on each instr_valid_i & err_detected_i cycle, and corr_cnt_o increments on each instr_valid_i & err_corrected_i cycle; both saturate at 2^CNT_W-1.
- Undefined: the counters are not built and both outputs are tied to 0.

Structure
REQ-034 The state enum typedef and the CDEC_MAX_RETRY and CDEC_STAT_CNT_W defaults SHALL reside in ft_pkg.
REQ-035 The saturating counter SHALL be a sub-module, cv32e40p_ft_sat_cnt, instantiated twice.

Verification
REQ-036 UE pulse at cycle 10 with retry_q=0: state STALL at cycle 11, REPLAY with replay_o=1 at cycle 12, RUN at cycle 13, retry_q=1.
REQ-037 Three consecutive replay-causing UEs with MAX_RETRY=2: the third UE leads to FATAL with fatal_o=1; clear_i then returns the FSM to RUN with retry_q=0.
REQ-038 is_broken_i=3'b001 followed by force_we_i with force_mask_i=3'b010: the write is rejected, reject_o=1 for one cycle, set_broken_o stays 3'b000.
REQ-039 UE and clear_i in the same cycle in RUN: the FSM stays in RUN and retry_q=0.
REQ-040 With CDEC_FT_STATS_EN and CNT_W=4: 20 detected-error cycles give err_cnt_o=15 (saturated).
REQ-041 rst asserted in the REPLAY state: the next cycle shows RUN with all outputs at 0.
